// File: rtl/context_event_reporter.sv
// Sticky TX event latch and fixed-priority trigger source for the VITA context packet generator.
// Holds the selected event's body/time/seqnum steady until the generator signals done.
module context_event_reporter #(
  parameter logic [31:0] SID_DEFAULT = 32'h0,
  parameter bit          REPORT_ACK  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [31:0] set_sid,
  input  logic        set_sid_stb,
  input  logic        ev_late,
  input  logic        ev_seqerr,
  input  logic        ev_underrun,
  input  logic        ev_ack,
  input  logic [11:0] ev_seqnum,
  input  logic [63:0] vita_time,
  output logic        trigger,
  output logic [11:0] seqnum,
  output logic [31:0] sid,
  output logic [63:0] body,
  output logic [63:0] pkt_time,
  input  logic        done,
  output logic [15:0] dropped
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_TRIG = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  // Slot index doubles as priority: 0 = LATE (highest) .. 3 = ACK (lowest).
  function automatic logic [31:0] ev_code(input logic [1:0] idx);
    case (idx)
      2'd0:    return 32'h8;
      2'd1:    return 32'h4;
      2'd2:    return 32'h2;
      default: return 32'h1;
    endcase
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [2:0] n);
    logic [16:0] s;
    s = {1'b0, a} + {14'd0, n};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  logic [1:0]  state;
  logic [3:0]  pend;
  logic [1:0]  sel;
  logic [63:0] slot_time [4];
  logic [11:0] slot_seq  [4];

  logic [3:0]  strb;
  logic [3:0]  reload;
  logic [3:0]  drop;
  logic [2:0]  n_drop;
  logic [3:0]  pend_nxt;
  logic [1:0]  pick;
  logic        served_done;

  always_comb begin
    strb        = {ev_ack & REPORT_ACK, ev_underrun, ev_seqerr, ev_late};
    served_done = (state == ST_WAIT) && done;
    reload      = '0;
    drop        = '0;
    n_drop      = '0;
    for (int i = 0; i < 4; i++) begin
      // A strobe on the slot being retired this cycle re-arms it instead of coalescing.
      reload[i] = served_done && (sel == i[1:0]) && strb[i];
      drop[i]   = strb[i] && pend[i] && !reload[i];
      n_drop    = n_drop + {2'd0, drop[i]};
    end
    pend_nxt = pend;
    if (served_done) pend_nxt[sel] = 1'b0;
    pend_nxt = pend_nxt | strb;
    if (pend[0])      pick = 2'd0;
    else if (pend[1]) pick = 2'd1;
    else if (pend[2]) pick = 2'd2;
    else              pick = 2'd3;
  end

  assign trigger = (state == ST_TRIG);

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (strb[i] && (!pend[i] || reload[i])) begin
        slot_time[i] <= vita_time;
        slot_seq[i]  <= ev_seqnum;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      pend     <= '0;
      sel      <= '0;
      seqnum   <= '0;
      sid      <= SID_DEFAULT;
      body     <= '0;
      pkt_time <= '0;
      dropped  <= '0;
    end else if (clear) begin
      state    <= ST_IDLE;
      pend     <= '0;
      sel      <= '0;
      seqnum   <= '0;
      sid      <= SID_DEFAULT;
      body     <= '0;
      pkt_time <= '0;
      dropped  <= '0;
    end else begin
      pend    <= pend_nxt;
      dropped <= sat_add(dropped, n_drop);
      case (state)
        ST_IDLE: begin
          if (set_sid_stb) sid <= set_sid;
          if (|pend) begin
            sel      <= pick;
            body     <= {ev_code(pick), 20'd0, slot_seq[pick]};
            pkt_time <= slot_time[pick];
            state    <= ST_TRIG;
          end
        end
        ST_TRIG: state <= ST_WAIT;
        ST_WAIT: begin
          if (done) begin
            seqnum <= seqnum + 12'd1;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
